// File: rtl/cache_data_array.sv
// cache_data_array
//   N-way set-associative line data store for the multi-cycle MIPS cache.
//   Each line holds LINE_WORDS words of WORD_W bits. The CPU side gets
//   single-cycle registered word reads and byte-enable word writes. A refill
//   sequencer streams a line in from memory, and an evict sequencer streams a
//   line out to memory.
//
// Ports
//   clk_i, rst_i        clock; asynchronous active-low reset
//   cpu_*               word access (served only while idle)
//   cpu_rdata_o/rvalid  registered read data, one-cycle valid pulse
//   fill_*              line refill: start + target, beat stream in, done pulse
//   evict_*             line evict: start + source, beat stream out, done pulse
//   busy_o              a refill or eviction is in progress
//
// Handshake rule (both streams): a beat transfers on a rising edge where the
// producer's valid and the consumer's ready are both high. The producer keeps
// its data stable while valid is high and ready is low.
//
// Array contents are never reset; a reset mid-refill leaves the beats already
// written in place.

module cache_data_array #(
    parameter int WAYS       = 2,
    parameter int SETS       = 32,
    parameter int LINE_WORDS = 8,
    parameter int WORD_W     = 32,
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int SET_W     = $clog2(SETS),
    localparam int OFF_W     = $clog2(LINE_WORDS),
    localparam int BE_W      = WORD_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [WAY_W-1:0]  cpu_way_i,
    input  logic [SET_W-1:0]  cpu_set_i,
    input  logic [OFF_W-1:0]  cpu_word_i,
    input  logic [BE_W-1:0]   cpu_be_i,
    input  logic [WORD_W-1:0] cpu_wdata_i,
    output logic [WORD_W-1:0] cpu_rdata_o,
    output logic              cpu_rvalid_o,

    input  logic              fill_start_i,
    input  logic [WAY_W-1:0]  fill_way_i,
    input  logic [SET_W-1:0]  fill_set_i,
    input  logic              fill_valid_i,
    input  logic [WORD_W-1:0] fill_data_i,
    output logic              fill_ready_o,
    output logic              fill_done_o,

    input  logic              evict_start_i,
    input  logic [WAY_W-1:0]  evict_way_i,
    input  logic [SET_W-1:0]  evict_set_i,
    output logic              evict_valid_o,
    output logic [WORD_W-1:0] evict_data_o,
    input  logic              evict_ready_i,
    output logic              evict_done_o,

    output logic              busy_o
);

    localparam int IDX_W = WAY_W + SET_W + OFF_W;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_EVICT = 2'd2
    } state_t;

    // Flat word array addressed by {way, set, word}.
    logic [WORD_W-1:0] mem_q [DEPTH];

    state_t            state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic [SET_W-1:0]  set_q, set_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              fill_done_q, fill_done_d;
    logic              evict_done_q, evict_done_d;
    logic [WORD_W-1:0] evict_data_q, evict_data_d;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [BE_W-1:0]   mem_be;
    logic [WORD_W-1:0] mem_wdata;

    logic [OFF_W-1:0]  cnt_inc;
    logic [IDX_W-1:0]  cpu_idx;
    logic [IDX_W-1:0]  line_idx;
    logic [IDX_W-1:0]  line_next_idx;
    logic [IDX_W-1:0]  evict_first_idx;

    assign cnt_inc         = cnt_q + OFF_W'(1);
    assign cpu_idx         = {cpu_way_i, cpu_set_i, cpu_word_i};
    assign line_idx        = {way_q, set_q, cnt_q};
    assign line_next_idx   = {way_q, set_q, cnt_inc};
    assign evict_first_idx = {evict_way_i, evict_set_i, {OFF_W{1'b0}}};

    // State register and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            way_q        <= '0;
            set_q        <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            fill_done_q  <= 1'b0;
            evict_done_q <= 1'b0;
            evict_data_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            way_q        <= way_d;
            set_q        <= set_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            fill_done_q  <= fill_done_d;
            evict_done_q <= evict_done_d;
            evict_data_q <= evict_data_d;
        end
    end

    // Next-state, array write port and output next values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        way_d        = way_q;
        set_d        = set_q;
        rdata_d      = rdata_q;
        rvalid_d     = 1'b0;
        fill_done_d  = 1'b0;
        evict_done_d = 1'b0;
        evict_data_d = evict_data_q;
        mem_we       = 1'b0;
        mem_widx     = line_idx;
        mem_be       = '0;
        mem_wdata    = fill_data_i;

        case (state_q)
            ST_IDLE: begin
                // A CPU access wins over any start in the same cycle.
                if (cpu_req_i) begin
                    if (cpu_we_i) begin
                        mem_we    = 1'b1;
                        mem_widx  = cpu_idx;
                        mem_be    = cpu_be_i;
                        mem_wdata = cpu_wdata_i;
                    end else begin
                        rdata_d  = mem_q[cpu_idx];
                        rvalid_d = 1'b1;
                    end
                end else if (evict_start_i) begin
                    state_d      = ST_EVICT;
                    way_d        = evict_way_i;
                    set_d        = evict_set_i;
                    cnt_d        = '0;
                    // Word 0 is loaded now so it is presented the cycle after start.
                    evict_data_d = mem_q[evict_first_idx];
                end else if (fill_start_i) begin
                    state_d = ST_FILL;
                    way_d   = fill_way_i;
                    set_d   = fill_set_i;
                    cnt_d   = '0;
                end
            end

            ST_FILL: begin
                if (fill_valid_i) begin
                    mem_we = 1'b1;
                    mem_be = '1;
                    cnt_d  = cnt_inc;
                    if (cnt_q == LAST_WORD) begin
                        state_d     = ST_IDLE;
                        fill_done_d = 1'b1;
                    end
                end
            end

            ST_EVICT: begin
                if (evict_ready_i) begin
                    cnt_d = cnt_inc;
                    if (cnt_q == LAST_WORD) begin
                        state_d      = ST_IDLE;
                        evict_done_d = 1'b1;
                        evict_data_d = '0;
                    end else begin
                        // Prefetch the following word so the stream has no bubble.
                        evict_data_d = mem_q[line_next_idx];
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Array write port: no reset, contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (mem_be[b]) begin
                    mem_q[mem_widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign cpu_rdata_o   = rdata_q;
    assign cpu_rvalid_o  = rvalid_q;
    assign fill_ready_o  = (state_q == ST_FILL);
    assign fill_done_o   = fill_done_q;
    assign evict_valid_o = (state_q == ST_EVICT);
    assign evict_data_o  = evict_data_q;
    assign evict_done_o  = evict_done_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cache_data_array.sv
module tb_cache_data_array;

    localparam int WAYS = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        cpu_req_i = 1'b0;
    logic        cpu_we_i = 1'b0;
    logic [1:0]  cpu_way_i = '0;
    logic [4:0]  cpu_set_i = '0;
    logic [2:0]  cpu_word_i = '0;
    logic [3:0]  cpu_be_i = '0;
    logic [31:0] cpu_wdata_i = '0;
    logic [31:0] cpu_rdata_o;
    logic        cpu_rvalid_o;
    logic        fill_start_i = 1'b0;
    logic [1:0]  fill_way_i = '0;
    logic [4:0]  fill_set_i = '0;
    logic        fill_valid_i = 1'b0;
    logic [31:0] fill_data_i = '0;
    logic        fill_ready_o;
    logic        fill_done_o;
    logic        evict_start_i = 1'b0;
    logic [1:0]  evict_way_i = '0;
    logic [4:0]  evict_set_i = '0;
    logic        evict_valid_o;
    logic [31:0] evict_data_o;
    logic        evict_ready_i = 1'b0;
    logic        evict_done_o;
    logic        busy_o;

    cache_data_array #(.WAYS(WAYS)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_way_i(cpu_way_i),
        .cpu_set_i(cpu_set_i), .cpu_word_i(cpu_word_i), .cpu_be_i(cpu_be_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_rvalid_o(cpu_rvalid_o),
        .fill_start_i(fill_start_i), .fill_way_i(fill_way_i), .fill_set_i(fill_set_i),
        .fill_valid_i(fill_valid_i), .fill_data_i(fill_data_i),
        .fill_ready_o(fill_ready_o), .fill_done_o(fill_done_o),
        .evict_start_i(evict_start_i), .evict_way_i(evict_way_i), .evict_set_i(evict_set_i),
        .evict_valid_o(evict_valid_o), .evict_data_o(evict_data_o),
        .evict_ready_i(evict_ready_i), .evict_done_o(evict_done_o),
        .busy_o(busy_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdata"}, cpu_rdata_o, 32'h0);
        check({tag, "_rvalid"}, {31'b0, cpu_rvalid_o}, 32'h0);
        check({tag, "_fill_ready"}, {31'b0, fill_ready_o}, 32'h0);
        check({tag, "_fill_done"}, {31'b0, fill_done_o}, 32'h0);
        check({tag, "_evict_valid"}, {31'b0, evict_valid_o}, 32'h0);
        check({tag, "_evict_data"}, evict_data_o, 32'h0);
        check({tag, "_evict_done"}, {31'b0, evict_done_o}, 32'h0);
        check({tag, "_busy"}, {31'b0, busy_o}, 32'h0);
    endtask

    function automatic logic [31:0] iso_pat(input int w, input int k);
        return 32'hA000_0000 | (32'(w) << 16) | 32'(k);
    endfunction

    // ---------------- driver tasks ----------------
    // One CPU access; returns after the edge that served it.
    task automatic cpu_op(input logic we, input logic [1:0] way, input logic [4:0] set,
                          input logic [2:0] word, input logic [3:0] be, input logic [31:0] wd);
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_way_i = way; cpu_set_i = set;
        cpu_word_i = word; cpu_be_i = be; cpu_wdata_i = wd;
        tick();
        cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    endtask

    // Refill one line with data base+k. gap inserts an idle beat before each
    // valid beat; poke issues CPU accesses mid-line that must be ignored.
    task automatic do_fill(input logic [1:0] way, input logic [4:0] set, input logic [31:0] base,
                           input bit gap, input bit poke);
        fill_way_i = way; fill_set_i = set; fill_start_i = 1'b1;
        tick();
        fill_start_i = 1'b0;
        check("fill_busy", {31'b0, busy_o}, 32'h1);
        check("fill_ready", {31'b0, fill_ready_o}, 32'h1);
        for (int k = 0; k < 8; k++) begin
            if (gap) begin
                fill_valid_i = 1'b0;
                tick();
                check("fill_gap_done", {31'b0, fill_done_o}, 32'h0);
            end
            if (poke && k == 4) begin
                fill_valid_i = 1'b0;
                cpu_op(1'b1, 2'd0, 5'd3, 3'd0, 4'hF, 32'hDEAD_BEEF);
                check("busy_write_rvalid", {31'b0, cpu_rvalid_o}, 32'h0);
                cpu_op(1'b0, 2'd0, 5'd3, 3'd1, 4'h0, 32'h0);
                check("busy_read_rvalid", {31'b0, cpu_rvalid_o}, 32'h0);
                check("busy_read_still_busy", {31'b0, busy_o}, 32'h1);
            end
            fill_valid_i = 1'b1;
            fill_data_i = base + 32'(k);
            tick();
            check(k == 7 ? "fill_done_pulse" : "fill_done_early", {31'b0, fill_done_o},
                  k == 7 ? 32'h1 : 32'h0);
        end
        fill_valid_i = 1'b0;
        check("fill_busy_fall", {31'b0, busy_o}, 32'h0);
        check("fill_ready_fall", {31'b0, fill_ready_o}, 32'h0);
        tick();
        check("fill_done_one_cycle", {31'b0, fill_done_o}, 32'h0);
    endtask

    // Evict a line and compare against exp_q. The beat numbered stall_beat is
    // held with ready low for stall_len cycles. with_fill also raises
    // fill_start_i in the start cycle, which must be ignored.
    task automatic do_evict(input logic [1:0] way, input logic [4:0] set,
                            input int stall_beat, input int stall_len, input bit with_fill);
        int beat;
        int stalls;
        int cyc;
        logic [31:0] e;
        beat = 0; stalls = 0; cyc = 0;
        evict_way_i = way; evict_set_i = set; evict_start_i = 1'b1;
        fill_way_i = way; fill_set_i = set; fill_start_i = with_fill;
        tick();
        evict_start_i = 1'b0; fill_start_i = 1'b0;
        while (beat < 8 && cyc < 64) begin
            check("evict_valid", {31'b0, evict_valid_o}, 32'h1);
            check("evict_done_early", {31'b0, evict_done_o}, 32'h0);
            if (with_fill) check("evict_fill_ready_low", {31'b0, fill_ready_o}, 32'h0);
            if (beat == stall_beat && stalls < stall_len) begin
                evict_ready_i = 1'b0;
                check("evict_hold", evict_data_o, exp_q[0]);
                stalls++;
            end else begin
                evict_ready_i = 1'b1;
                e = exp_q.pop_front();
                check("evict_data", evict_data_o, e);
                beat++;
            end
            tick();
            cyc++;
        end
        evict_ready_i = 1'b0;
        if (beat < 8) check("evict_timeout_beats", 32'(beat), 32'd8);
        check("evict_done_pulse", {31'b0, evict_done_o}, 32'h1);
        check("evict_busy_fall", {31'b0, busy_o}, 32'h0);
        check("evict_valid_fall", {31'b0, evict_valid_o}, 32'h0);
        check("evict_q_empty", 32'(exp_q.size()), 32'd0);
        tick();
        check("evict_done_one_cycle", {31'b0, evict_done_o}, 32'h0);
    endtask

    // ---------------- CPU vector table ----------------
    typedef struct {
        logic        we;
        logic [1:0]  way;
        logic [4:0]  set;
        logic [2:0]  word;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // Reads of the gapped refill, then byte-lane merges on another line.
        for (int k = 0; k < 8; k++)
            vecs[k] = '{1'b0, 2'd1, 5'd5, 3'(k), 4'h0, 32'h0, 32'h1000_0000 + 32'(k)};
        vecs[8]  = '{1'b1, 2'd0, 5'd2, 3'd3, 4'hF, 32'h1122_3344, 32'h0};
        vecs[9]  = '{1'b1, 2'd0, 5'd2, 3'd3, 4'b0101, 32'hAABB_CCDD, 32'h0};
        vecs[10] = '{1'b0, 2'd0, 5'd2, 3'd3, 4'h0, 32'h0, 32'h11BB_33DD};
        vecs[11] = '{1'b1, 2'd0, 5'd2, 3'd3, 4'b1010, 32'h5566_7788, 32'h0};
        vecs[12] = '{1'b0, 2'd0, 5'd2, 3'd3, 4'h0, 32'h0, 32'h55BB_77DD};
        vecs[13] = '{1'b1, 2'd0, 5'd2, 3'd3, 4'b0000, 32'hFFFF_FFFF, 32'h0};
        vecs[14] = '{1'b1, 2'd0, 5'd2, 3'd4, 4'hF, 32'hCAFE_F00D, 32'h0};
        vecs[15] = '{1'b0, 2'd0, 5'd2, 3'd3, 4'h0, 32'h0, 32'h55BB_77DD};

        // Reset
        rst_i = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        rst_i = 1'b1;
        tick();

        // Gapped refill of way 1 / set 5
        do_fill(2'd1, 5'd5, 32'h1000_0000, 1'b1, 1'b0);

        // CPU table
        for (int i = 0; i < 16; i++) begin
            cpu_op(vecs[i].we, vecs[i].way, vecs[i].set, vecs[i].word, vecs[i].be, vecs[i].wdata);
            check("cpu_rvalid", {31'b0, cpu_rvalid_o}, {31'b0, ~vecs[i].we});
            if (!vecs[i].we) check("cpu_rdata", cpu_rdata_o, vecs[i].exp);
        end
        cpu_op(1'b0, 2'd0, 5'd2, 3'd4, 4'h0, 32'h0);
        check("cpu_rdata_word4", cpu_rdata_o, 32'hCAFE_F00D);
        tick();
        check("cpu_rvalid_pulse", {31'b0, cpu_rvalid_o}, 32'h0);

        // Evict way 1 / set 5 with a 3-cycle stall on beat 2
        for (int k = 0; k < 8; k++) exp_q.push_back(32'h1000_0000 + 32'(k));
        do_evict(2'd1, 5'd5, 2, 3, 1'b0);

        // Simultaneous starts: eviction wins, refill ignored
        for (int k = 0; k < 8; k++) exp_q.push_back(32'h1000_0000 + 32'(k));
        do_evict(2'd1, 5'd5, -1, 0, 1'b1);

        // CPU request together with a refill start: CPU served, no start
        fill_way_i = 2'd1; fill_set_i = 5'd5; fill_start_i = 1'b1;
        cpu_op(1'b0, 2'd1, 5'd5, 3'd4, 4'h0, 32'h0);
        fill_start_i = 1'b0;
        check("cpu_vs_start_rvalid", {31'b0, cpu_rvalid_o}, 32'h1);
        check("cpu_vs_start_rdata", cpu_rdata_o, 32'h1000_0004);
        check("cpu_vs_start_busy", {31'b0, busy_o}, 32'h0);
        check("cpu_vs_start_fill_ready", {31'b0, fill_ready_o}, 32'h0);
        tick();

        // Way isolation on set 3; CPU accesses during the last refill are ignored
        for (int w = 0; w < 4; w++)
            do_fill(2'(w), 5'd3, iso_pat(w, 0), 1'b0, w == 3);
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 8; k++) begin
                cpu_op(1'b0, 2'(w), 5'd3, 3'(k), 4'h0, 32'h0);
                check("iso_rvalid", {31'b0, cpu_rvalid_o}, 32'h1);
                check("iso_rdata", cpu_rdata_o, iso_pat(w, k));
            end
        end

        // Reset in the middle of an eviction
        evict_way_i = 2'd2; evict_set_i = 5'd3; evict_start_i = 1'b1;
        tick();
        evict_start_i = 1'b0; evict_ready_i = 1'b1;
        tick(); tick(); tick();
        check("mid_evict_data", evict_data_o, iso_pat(2, 3));
        rst_i = 1'b0;
        #1;
        check_all_zero("mid_reset");
        evict_ready_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        check("post_reset_busy", {31'b0, busy_o}, 32'h0);
        check("post_reset_evict_valid", {31'b0, evict_valid_o}, 32'h0);
        cpu_op(1'b0, 2'd1, 5'd5, 3'd6, 4'h0, 32'h0);
        check("post_reset_rvalid", {31'b0, cpu_rvalid_o}, 32'h1);
        check("post_reset_rdata", cpu_rdata_o, 32'h1000_0006);
        cpu_op(1'b0, 2'd2, 5'd3, 3'd5, 4'h0, 32'h0);
        check("post_reset_rdata_iso", cpu_rdata_o, iso_pat(2, 5));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_data_array.md
# cache_data_array

Parametrised, N-way set-associative data store for the multi-cycle MIPS cache, successor to the single-way 256-bit line array. Lines are held as LINE_WORDS words of WORD_W bits. The CPU side gets registered word reads and byte-enable word writes. A line-refill FSM streams words in from memory, and a line-evict FSM streams words out to memory, each with valid/ready handshakes. Sits between the cache controller (tag/hit logic, way selection) and the memory interface.

## Interface
- WAYS, 2, number of ways (power of 2, ≥1); WAY_W = max(1, clog2(WAYS))
- SETS, 32, sets per way (power of 2); SET_W = clog2(SETS)
- LINE_WORDS, 8, words per line (power of 2, ≥2); OFF_W = clog2(LINE_WORDS)
- WORD_W, 32, word width (multiple of 8); BE_W = WORD_W/8

Ports:
- clk_i  in  1  single clock, all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- cpu_req_i  in  1  CPU word access request
- cpu_we_i  in  1  1 = write, 0 = read
- cpu_way_i  in  WAY_W  target way
- cpu_set_i  in  SET_W  target set
- cpu_word_i  in  OFF_W  word offset in line
- cpu_be_i  in  BE_W  byte enables for writes
- cpu_wdata_i  in  WORD_W  write data
- cpu_rdata_o  out  WORD_W  registered read data
- cpu_rvalid_o  out  1  one-cycle pulse, cpu_rdata_o valid
- fill_start_i  in  1  begin line refill
- fill_way_i / fill_set_i  in  WAY_W / SET_W  refill target
- fill_valid_i  in  1  refill beat valid
- fill_data_i  in  WORD_W  refill beat data
- fill_ready_o  out  1  refill beat accepted when high
- fill_done_o  out  1  one-cycle pulse, line fully written
- evict_start_i  in  1  begin line eviction
- evict_way_i / evict_set_i  in  WAY_W / SET_W  eviction source
- evict_valid_o  out  1  eviction beat valid
- evict_data_o  out  WORD_W  eviction beat data
- evict_ready_i  in  1  downstream accepts beat
- evict_done_o  out  1  one-cycle pulse, last beat transferred
- busy_o  out  1  FSM not IDLE

## Operation
- FSM states: IDLE, FILL, EVICT. Reset puts the FSM in IDLE.
- IDLE, cpu_req_i=1, the request is served and any start request in the same cycle is ignored:
  - Read latches the word into cpu_rdata_o and pulses cpu_rvalid_o.
  - Write updates only the byte lanes where cpu_be_i[b]=1. Other lanes and other words keep their values. No rvalid pulse.
- IDLE, cpu_req_i=0:
  - evict_start_i has priority over fill_start_i.
  - Start latches way/set, clears beat counter cnt, and moves the FSM to EVICT or FILL.
- cpu_req_i while busy_o=1: ignored, no array effect, no rvalid. The controller must hold off.
- FILL:
  - fill_ready_o=1.
  - Each cycle with fill_valid_i=1 writes fill_data_i to word cnt of the latched line (all bytes) and increments cnt.
  - The beat at cnt=LINE_WORDS-1 sends the FSM to IDLE and sets fill_done_o for the next cycle.
  - Gaps (fill_valid_i=0) are allowed.
- EVICT:
  - evict_valid_o=1 with evict_data_o = word cnt, held stable until evict_ready_i=1.
  - On handshake, cnt increments and the next word is presented the following cycle with no bubble.
  - The handshake on the last word sends the FSM to IDLE and sets evict_done_o for the next cycle.
- Start inputs during FILL/EVICT are ignored.
- Reset mid-operation: FSM to IDLE, all outputs 0, array contents not cleared. A partially filled line keeps the beats already written.
- Array contents are not reset and are undefined until written.

## Timing
- Reset values: cpu_rdata_o=0, cpu_rvalid_o=0, fill_ready_o=0, fill_done_o=0, evict_valid_o=0, evict_data_o=0, evict_done_o=0, busy_o=0.
- CPU read latency: 1 cycle. Request at edge N gives data and rvalid in cycle N+1.
- CPU write visibility: a write at edge N is visible to a read issued at edge N+1.
- busy_o rises the cycle after start is accepted and falls in the same cycle the done pulse is high.
- fill_ready_o and evict_valid_o are registered, first asserted the cycle after start.
- Back-to-back fill: start in cycle 0, beats in cycles 1..LINE_WORDS, fill_done_o in cycle LINE_WORDS+1.
- Eviction with evict_ready_i=1 continuously: words in cycles 1..LINE_WORDS, evict_done_o in cycle LINE_WORDS+1.
- A new start or CPU request is accepted in the done cycle.

## Test plan
- Reset low mid-EVICT → all outputs 0 within the reset cycle. After release: busy_o=0, evict_valid_o=0, and a CPU read of a previously filled word returns its value.
- Fill way 1 / set 5 with words 0x1000_0000+k (k=0..7), fill_valid_i toggling every other cycle → fill_done_o one pulse after the 8th beat. CPU reads of words 0..7 return 0x1000_0000..0x1000_0007, each at 1-cycle latency.
- Write 0xAABBCCDD with cpu_be_i=4'b0101 to a word holding 0x1122_3344, then read on the next cycle → 0x11BB_33DD.
- Evict the same line with evict_ready_i low for 3 cycles on beat 2 → evict_data_o holds 0x1000_0002 stable. Order 0..7 with no drops or duplicates; evict_done_o after beat 7.
- fill_start_i and evict_start_i in the same IDLE cycle → EVICT entered, fill ignored (fill_ready_o stays 0). cpu_req_i with fill_start_i → CPU served, no start.
- Way isolation with WAYS=4: fill set 3 in ways 0..3 with distinct patterns → reads of each way return only its own pattern. cpu_req_i during FILL → cpu_rvalid_o stays 0 and array unchanged.
